// File: rtl/pwm_duty_ramp_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_duty_ramp_if : target handshake and duty/status for the ramp  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface pwm_duty_ramp_if #(
   parameter int PWM_RESOLUTION_c = 10
);
   logic [PWM_RESOLUTION_c-1:0] TARGET_i;
   logic                        TARGET_VALID_i;
   logic                        TARGET_READY_o;
   logic [PWM_RESOLUTION_c-1:0] DUTY_o;
   logic                        BUSY_o;
   logic                        DONE_o;

   modport master (
      output TARGET_i,
      output TARGET_VALID_i,
      input  TARGET_READY_o,
      input  DUTY_o,
      input  BUSY_o,
      input  DONE_o
   );

   modport slave (
      input  TARGET_i,
      input  TARGET_VALID_i,
      output TARGET_READY_o,
      output DUTY_o,
      output BUSY_o,
      output DONE_o
   );
endinterface
`default_nettype wire

// File: rtl/pwm_duty_ramp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_duty_ramp : slew-rate limited duty output toward a target     |
// | Option macro PWM_DUTY_RAMP_RETARGET_EN enables mid-ramp retarget. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module pwm_duty_ramp #(
   parameter int CLK_FREQ_c       = 100_000_000,
   parameter int STEP_FREQ_c      = 1_000,
   parameter int PWM_RESOLUTION_c = 10,
   parameter int STEP_SIZE_c      = 1
) (
   input  wire  CLK_i,
   input  wire  RESET_i,
   input  wire  EN_i,
   pwm_duty_ramp_if.slave bus
);

   localparam int STEP_LIMIT_RAW = (CLK_FREQ_c + (STEP_FREQ_c / 2)) / STEP_FREQ_c;
   localparam int STEP_LIMIT     = (STEP_LIMIT_RAW < 1) ? 1 : STEP_LIMIT_RAW;
   localparam int CNT_W          = (STEP_LIMIT > 1) ? $clog2(STEP_LIMIT) : 1;
   localparam int W              = PWM_RESOLUTION_c;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_LIMIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [W:0]       STEP_EXT = (W+1)'(STEP_SIZE_c);
   localparam logic [W-1:0]     STEP_VAL = W'(STEP_SIZE_c);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     target_q, target_d;
   logic [W-1:0]     duty_q, duty_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             tick;
   logic             accept;
   logic [W:0]       diff_up;
   logic [W:0]       diff_dn;

   assign tick    = (cnt_q == CNT_LAST);
   assign accept  = bus.TARGET_VALID_i & ready_q;
   assign diff_up = {1'b0, target_q} - {1'b0, duty_q};
   assign diff_dn = {1'b0, duty_q} - {1'b0, target_q};

   always_comb begin
      state_d  = state_q;
      cnt_d    = tick ? '0 : (cnt_q + CNT_ONE);
      target_d = target_q;
      duty_d   = duty_q;
      done_d   = 1'b0;

      // An accept coinciding with a tick takes that edge; the step resumes on the next tick.
      if (accept) begin
         target_d = bus.TARGET_i;
`ifdef PWM_DUTY_RAMP_RETARGET_EN
         if (state_q == ST_IDLE) begin
            cnt_d = '0;
         end
`else
         cnt_d = '0;
`endif
         if (bus.TARGET_i > duty_q) begin
            state_d = ST_UP;
         end else if (bus.TARGET_i < duty_q) begin
            state_d = ST_DOWN;
         end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
      end else if (tick) begin
         case (state_q)
            ST_UP: begin
               if (diff_up <= STEP_EXT) begin
                  duty_d  = target_q;
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  duty_d = duty_q + STEP_VAL;
               end
            end
            ST_DOWN: begin
               if (diff_dn <= STEP_EXT) begin
                  duty_d  = target_q;
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  duty_d = duty_q - STEP_VAL;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
`ifdef PWM_DUTY_RAMP_RETARGET_EN
      ready_d = 1'b1;
`else
      ready_d = (state_d == ST_IDLE);
`endif

      if (!EN_i) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         target_d = '0;
         duty_d   = '0;
         done_d   = 1'b0;
         busy_d   = 1'b0;
         ready_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK_i) begin
      if (RESET_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         target_q <= '0;
         duty_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= EN_i;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
         duty_q   <= duty_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
      end
   end

   assign bus.TARGET_READY_o = ready_q;
   assign bus.DUTY_o         = duty_q;
   assign bus.BUSY_o         = busy_q;
   assign bus.DONE_o         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_ramp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pwm_duty_ramp : directed and random ramps vs. an arithmetic    |
// | trajectory model. Rev 1.0                                         |
// +------------------------------------------------------------------+
module tb_pwm_duty_ramp;

   localparam int CLK_F = 100;
   localparam int STEP_F = 10;
   localparam int RES = 10;
   localparam int STEP = 4;
   localparam int L = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;
   int model_duty = 0;

   always #5 clk = ~clk;

   pwm_duty_ramp_if #(.PWM_RESOLUTION_c(RES)) bus ();

   pwm_duty_ramp #(
      .CLK_FREQ_c      (CLK_F),
      .STEP_FREQ_c     (STEP_F),
      .PWM_RESOLUTION_c(RES),
      .STEP_SIZE_c     (STEP)
   ) dut (
      .CLK_i  (clk),
      .RESET_i(rst),
      .EN_i   (en),
      .bus    (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic int dist_of(input int d0, input int t);
      return (t >= d0) ? (t - d0) : (d0 - t);
   endfunction

   // Duty c cycles after the accept edge: moves STEP per L cycles, clamped to the target.
   function automatic int ramp_duty(input int d0, input int t, input int c);
      int mv;
      mv = (c / L) * STEP;
      if (mv > dist_of(d0, t)) mv = dist_of(d0, t);
      return (t >= d0) ? (d0 + mv) : (d0 - mv);
   endfunction

   function automatic int ramp_len(input int d0, input int t);
      return ((dist_of(d0, t) + STEP - 1) / STEP) * L;
   endfunction

   task automatic check_idle(input string tag, input int duty, input logic rdy);
      check({tag, "_duty"},  bus.DUTY_o, duty);
      check({tag, "_busy"},  bus.BUSY_o, 0);
      check({tag, "_done"},  bus.DONE_o, 0);
      check({tag, "_ready"}, bus.TARGET_READY_o, rdy);
   endtask

   // Accepts target t and follows the ramp up to stop_c cycles past the accept edge.
   task automatic start_and_follow(input int t, input int stop_c);
      int d0;
      int tl;
      int w;
      d0 = model_duty;
      tl = ramp_len(d0, t);
      w = 0;
      while (bus.TARGET_READY_o !== 1'b1 && w < 50) begin
         step_cycle();
         w++;
      end
      check("ready_before_accept", bus.TARGET_READY_o, 1);
      bus.TARGET_i = RES'(t);
      bus.TARGET_VALID_i = 1'b1;
      step_cycle();
      bus.TARGET_VALID_i = 1'b0;
      bus.TARGET_i = RES'($urandom);
      for (int c = 0; c <= stop_c; c++) begin
         if (c > 0) step_cycle();
         check("duty", bus.DUTY_o, ramp_duty(d0, t, c));
         check("busy", bus.BUSY_o, (c < tl) ? 1 : 0);
         check("done", bus.DONE_o, (c == tl) ? 1 : 0);
`ifdef PWM_DUTY_RAMP_RETARGET_EN
         check("ready", bus.TARGET_READY_o, 1);
`else
         check("ready", bus.TARGET_READY_o, (c >= tl) ? 1 : 0);
`endif
      end
   endtask

   task automatic ramp_to(input int t);
      start_and_follow(t, ramp_len(model_duty, t) + 1);
      model_duty = t;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int tl;
      int exp_d;
      bus.TARGET_i = '0;
      bus.TARGET_VALID_i = 1'b0;
      rst = 1'b1;
      en = 1'b1;
      repeat (3) step_cycle();
      check_idle("reset", 0, 1'b1);
      rst = 1'b0;
      step_cycle();
      check_idle("post_reset", 0, 1'b1);

      // Equal target: DONE pulse only, BUSY stays low.
      ramp_to(0);
      ramp_to(10);
      ramp_to(0);
      ramp_to(1020);
      ramp_to(1023);
      ramp_to(0);

      // EN dropped for one cycle at duty 8 abandons the ramp.
      start_and_follow(40, 23);
      en = 1'b0;
      step_cycle();
      check_idle("en_low", 0, 1'b0);
      en = 1'b1;
      step_cycle();
      check_idle("en_back", 0, 1'b1);
      for (int i = 0; i < 15; i++) begin
         step_cycle();
         check_idle("after_en", 0, 1'b1);
      end
      model_duty = 0;

      // Reset mid-ramp behaves the same way.
      start_and_follow(200, 35);
      rst = 1'b1;
      step_cycle();
      check_idle("mid_reset", 0, 1'b1);
      rst = 1'b0;
      step_cycle();
      check_idle("after_reset", 0, 1'b1);
      model_duty = 0;

      // Request a new target 8 while at duty 20 on the way to 100.
      start_and_follow(100, 53);
      bus.TARGET_i = RES'(8);
      bus.TARGET_VALID_i = 1'b1;
      step_cycle();
      bus.TARGET_VALID_i = 1'b0;
`ifdef PWM_DUTY_RAMP_RETARGET_EN
      tl = 80;
      for (int c = 54; c <= tl + 1; c++) begin
         if (c > 54) step_cycle();
         exp_d = 20 - (((c - 50) / L) * STEP > 12 ? 12 : ((c - 50) / L) * STEP);
         check("rt_duty", bus.DUTY_o, exp_d);
         check("rt_busy", bus.BUSY_o, (c < tl) ? 1 : 0);
         check("rt_done", bus.DONE_o, (c == tl) ? 1 : 0);
         check("rt_ready", bus.TARGET_READY_o, 1);
      end
      model_duty = 8;
`else
      tl = ramp_len(0, 100);
      for (int c = 54; c <= tl + 1; c++) begin
         if (c > 54) step_cycle();
         check("rt_duty", bus.DUTY_o, ramp_duty(0, 100, c));
         check("rt_busy", bus.BUSY_o, (c < tl) ? 1 : 0);
         check("rt_done", bus.DONE_o, (c == tl) ? 1 : 0);
         check("rt_ready", bus.TARGET_READY_o, (c >= tl) ? 1 : 0);
      end
      model_duty = 100;
`endif

      // Random targets with random idle gaps.
      repeat (6) begin
         int gap;
         gap = $urandom_range(0, 5);
         for (int i = 0; i < gap; i++) begin
            step_cycle();
            check_idle("gap", model_duty, 1'b1);
         end
         ramp_to($urandom_range(0, 1023));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
